encoder_quad_ctrl: RTL and testbench
====================================

Name: encoder_quad_ctrl

Overview:
- Consumes debounced quadrature A/B from the encoder front end and sequences sampling on a fixed-rate tick.
- Decodes Gray-code transitions and accumulates sub-steps into detents.
- Maintains a bounded position register and hands per-detent step events to the UI/control logic over a valid/ready handshake.
- Sits between the encoder debounce stage and any consumer that needs position or step events.

Parameters:
- width_p, 8: width of pos_o, unsigned.
- max_pos_p, 255: upper position bound. Lower bound is 0. Must satisfy max_pos_p <= 2^width_p - 1.
- div_p, 100: sample tick period in clk cycles. Must be >= 2.
- steps_per_detent_p, 4: quadrature sub-steps per detent. Legal values are 1, 2 or 4.

Ports:
- clk  in  1  system clock; everything is on posedge.
- reset_i  in  1  synchronous reset, active-high.
- A_i  in  1  debounced channel A.
- B_i  in  1  debounced channel B.
- clear_i  in  1  synchronous soft clear of position, sub-step and sticky flags.
- pos_o  out  width_p  current position.
- step_valid_o  out  1  step event pending.
- step_dir_o  out  1  event direction: 1 = CW/increment, 0 = CCW/decrement. Held stable while valid.
- step_ready_i  in  1  consumer accepts the event.
- err_o  out  1  sticky flag: illegal transition seen (both channels changed between ticks).
- drop_o  out  1  sticky flag: step event lost because the output was busy.

Behaviour:
- Reset state: every output is 0 on the cycle after reset_i is sampled high. Internal state also clears: div counter, sub-step accumulator, primed flag, and previous-AB register (00). Reset overrides all other inputs.
- Tick generation:
  - div counter runs 0..div_p-1 and wraps.
  - tick is asserted in the cycle the counter equals div_p-1.
  - Ticks occur exactly every div_p cycles, starting div_p cycles after reset is released.
- Priming: the first tick after reset or clear_i only loads prev_ab <= {A_i,B_i} and sets primed. No decode happens on that tick.
- Decode on each primed tick: cur = {A_i,B_i}.
  - CW sequence is 00->01->11->10->00 and gives +1.
  - The reverse sequence gives -1.
  - cur == prev gives 0.
  - Both bits changed: no count and err_o is set. prev is still updated.
  - prev_ab <= cur on every primed tick.
- Sub-step accumulator: signed, range -(steps_per_detent_p-1)..+(steps_per_detent_p-1).
  - On +1: if accumulator == steps_per_detent_p-1, it clears to 0 and a +detent is generated. Otherwise it increments.
  - On -1: symmetric, generating a -detent.
  - A direction reversal mid-detent simply counts back; there is no hysteresis.
- Position update on a detent:
  - +detent: pos <= pos+1, saturating at max_pos_p.
  - -detent: pos <= pos-1, saturating at 0.
  - Position update latency: pos_o changes on the cycle after the tick edge.
- Step event output (one-entry register):
  - A detent sets step_valid_o=1 and step_dir_o per detent direction, visible one cycle after the tick. This happens even if pos saturated.
  - Handshake completes in a cycle where step_valid_o && step_ready_i. step_valid_o drops the next cycle unless a new detent is loaded in that same cycle.
  - A new detent while step_valid_o=1 and step_ready_i=0: the event is discarded, drop_o is set, and the held event is unchanged. Position still updates.
  - A new detent in the same cycle as an acceptance: the new event is loaded, valid stays 1, and there is no drop.
  - step_dir_o must not change while valid && !ready.
- clear_i, when sampled high:
  - pos, accumulator, err_o, drop_o, step_valid_o and primed clear to 0.
  - clear_i has priority over a coincident tick; that tick's decode is discarded.
  - The div counter is not reset.
- Sticky flags err_o and drop_o clear only on reset_i or clear_i.

Optional Feature:
- Macro: ENCODER_QUAD_WRAP_EN.
- Defined: position wraps instead of saturating. max_pos_p+1 becomes 0, and 0-1 becomes max_pos_p.
- Undefined: saturating behaviour as above.
- Step events are generated identically in both modes.

Test Plan:
- Reset, then hold A=B=0 for 10 ticks -> pos_o=0, step_valid_o never asserts, err_o=0. First tick only primes.
- CW sequence 00,01,11,10,00, one change per tick, step_ready_i=1, steps_per_detent_p=4 -> exactly one event with step_dir_o=1, pos_o=1. Valid lasts 1 cycle.
- 3 CW sub-steps then 3 CCW sub-steps -> no event, pos_o unchanged. Then 4 CCW sub-steps from pos 0 -> one event with dir=0, pos_o stays 0 (saturated); with ENCODER_QUAD_WRAP_EN, pos_o=255.
- step_ready_i=0 while 2 CW detents occur -> step_valid_o=1, dir=1 held, drop_o=1, pos_o=2. Raise ready -> valid drops the next cycle.
- AB jumps 00->11 in one tick -> err_o=1, pos and accumulator unchanged. Pulse clear_i -> err_o=0, pos_o=0, next tick primes only.
- Assert reset_i mid-detent (accumulator=2, valid=1) -> all outputs 0 the next cycle; div counter restarts and the first tick arrives div_p cycles later.

Source files
------------

// File: rtl/encoder_quad_ctrl.sv
// rtl/encoder_quad_ctrl.sv - quadrature decoder with detent accumulator, bounded position and step-event handshake
// Define ENCODER_QUAD_WRAP_EN to make the position wrap at its bounds instead of saturating.
module encoder_quad_ctrl #(
   parameter int width_p            = 8,
   parameter int max_pos_p          = 255,
   parameter int div_p              = 100,
   parameter int steps_per_detent_p = 4
) (
   input  logic               clk,
   input  logic               reset_i,
   input  logic               A_i,
   input  logic               B_i,
   input  logic               clear_i,
   output logic [width_p-1:0] pos_o,
   output logic               step_valid_o,
   output logic               step_dir_o,
   input  logic               step_ready_i,
   output logic               err_o,
   output logic               drop_o
);

   localparam int cnt_w = $clog2(div_p);
   localparam logic [cnt_w-1:0]   cnt_last = cnt_w'(div_p - 1);
   localparam logic [width_p-1:0] pos_max  = width_p'(max_pos_p);
   localparam logic signed [3:0]  acc_top  = 4'(steps_per_detent_p - 1);

   logic [cnt_w-1:0]   cnt;
   logic               tick;
   logic               primed;
   logic [1:0]         prev_ab;
   logic [1:0]         cur_ab;
   logic               step_cw;
   logic               step_ccw;
   logic               illegal;
   logic signed [3:0]  acc;
   logic signed [3:0]  acc_next;
   logic               detent_up;
   logic               detent_dn;
   logic [width_p-1:0] pos_next;

   always_comb begin
      cur_ab   = {A_i, B_i};
      tick     = (cnt == cnt_last);
      step_cw  = 1'b0;
      step_ccw = 1'b0;
      // Gray sequence 00->01->11->10->00 is clockwise.
      case ({prev_ab, cur_ab})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_cw  = 1'b1;
         4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_ccw = 1'b1;
         default: ;
      endcase
      illegal = ((prev_ab ^ cur_ab) == 2'b11);
   end

   always_comb begin
      acc_next  = acc;
      detent_up = 1'b0;
      detent_dn = 1'b0;
      if (tick && primed) begin
         if (step_cw) begin
            if (acc == acc_top) begin
               acc_next  = 4'sd0;
               detent_up = 1'b1;
            end else begin
               acc_next = acc + 4'sd1;
            end
         end else if (step_ccw) begin
            if (acc == -acc_top) begin
               acc_next  = 4'sd0;
               detent_dn = 1'b1;
            end else begin
               acc_next = acc - 4'sd1;
            end
         end
      end
   end

   always_comb begin
      pos_next = pos_o;
`ifdef ENCODER_QUAD_WRAP_EN
      if (detent_up) begin
         pos_next = (pos_o == pos_max) ? '0 : pos_o + 1'b1;
      end else if (detent_dn) begin
         pos_next = (pos_o == '0) ? pos_max : pos_o - 1'b1;
      end
`else
      if (detent_up && (pos_o != pos_max)) begin
         pos_next = pos_o + 1'b1;
      end else if (detent_dn && (pos_o != '0)) begin
         pos_next = pos_o - 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         cnt          <= '0;
         primed       <= 1'b0;
         prev_ab      <= 2'b00;
         acc          <= 4'sd0;
         pos_o        <= '0;
         step_valid_o <= 1'b0;
         step_dir_o   <= 1'b0;
         err_o        <= 1'b0;
         drop_o       <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (clear_i) begin
            // The divider keeps running so tick spacing is unaffected by a soft clear.
            primed       <= 1'b0;
            acc          <= 4'sd0;
            pos_o        <= '0;
            step_valid_o <= 1'b0;
            err_o        <= 1'b0;
            drop_o       <= 1'b0;
         end else begin
            if (tick) begin
               prev_ab <= cur_ab;
               primed  <= 1'b1;
            end
            if (tick && primed && illegal) begin
               err_o <= 1'b1;
            end
            acc   <= acc_next;
            pos_o <= pos_next;
            if (detent_up || detent_dn) begin
               if (!step_valid_o || step_ready_i) begin
                  step_valid_o <= 1'b1;
                  step_dir_o   <= detent_up;
               end else begin
                  drop_o <= 1'b1;
               end
            end else if (step_valid_o && step_ready_i) begin
               step_valid_o <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_encoder_quad_ctrl.sv
// tb/tb_encoder_quad_ctrl.sv - directed table, corner sequences and random walk against a behavioural model
module tb_encoder_quad_ctrl;

   localparam int D    = 5;
   localparam int SPD  = 4;
   localparam int MAXP = 20;
`ifdef ENCODER_QUAD_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       clr;
   logic [1:0] ab;
   logic       ready;
   logic [7:0] pos;
   logic       valid;
   logic       dir;
   logic       err;
   logic       drop;

   encoder_quad_ctrl #(
      .width_p(8), .max_pos_p(MAXP), .div_p(D), .steps_per_detent_p(SPD)
   ) dut (
      .clk(clk), .reset_i(reset), .A_i(ab[1]), .B_i(ab[0]), .clear_i(clr),
      .pos_o(pos), .step_valid_o(valid), .step_dir_o(dir),
      .step_ready_i(ready), .err_o(err), .drop_o(drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int passed = 0;
   int total  = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Reference model: position in Gray order, signed sub-step count, one-slot event.
   int m_cnt, m_pos, m_acc, m_prev, m_cur, m_d, m_det;
   bit m_valid, m_dir, m_err, m_drop, m_primed, m_tick;

   function automatic int gidx(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   always @(posedge clk) begin
      m_tick = 1'b0;
      if (reset) begin
         m_cnt = 0; m_pos = 0; m_acc = 0; m_prev = 0;
         m_valid = 0; m_dir = 0; m_err = 0; m_drop = 0; m_primed = 0;
      end else begin
         m_cnt++;
         m_tick = (m_cnt % D == 0);
         if (clr) begin
            m_pos = 0; m_acc = 0; m_err = 0; m_drop = 0; m_valid = 0; m_primed = 0;
         end else begin
            m_det = 0;
            if (m_valid && ready) m_valid = 0;
            if (m_tick) begin
               m_cur = gidx(ab);
               if (!m_primed) begin
                  m_primed = 1;
               end else begin
                  m_d = (m_cur - m_prev + 4) % 4;
                  if (m_d == 2) m_err = 1;
                  else if (m_d == 1) m_acc++;
                  else if (m_d == 3) m_acc--;
                  if (m_acc == SPD) begin m_acc = 0; m_det = 1; end
                  if (m_acc == -SPD) begin m_acc = 0; m_det = -1; end
               end
               m_prev = m_cur;
            end
            if (m_det != 0) begin
               if (WRAP) m_pos = (m_pos + m_det + MAXP + 1) % (MAXP + 1);
               else if (m_pos + m_det >= 0 && m_pos + m_det <= MAXP) m_pos = m_pos + m_det;
               if (!m_valid) begin m_valid = 1; m_dir = (m_det > 0); end
               else m_drop = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_pos", pos, m_pos);
         chk("m_valid", valid, m_valid);
         if (m_valid) chk("m_dir", dir, m_dir);
         chk("m_err", err, m_err);
         chk("m_drop", drop, m_drop);
      end
   end

   task automatic next_tick();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_tick && n <= 2 * D);
      if (!m_tick) begin
         total++;
         $display("FAIL tick_timeout: got no tick in %0d cycles expected one within %0d", n, D);
      end
   endtask

   typedef struct {
      logic [1:0] ab;
      logic       ready;
      int         pos;
      logic       valid;
      logic       dir;
      logic       err;
      logic       drop;
   } vec_t;

   vec_t       tv [29];
   logic [1:0] seq [4];
   int         gi;
   int         r;

   initial begin
      seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
      tv[0]  = '{2'b00, 1, 0, 0, 0, 0, 0};
      tv[1]  = '{2'b01, 1, 0, 0, 0, 0, 0};
      tv[2]  = '{2'b11, 1, 0, 0, 0, 0, 0};
      tv[3]  = '{2'b10, 1, 0, 0, 0, 0, 0};
      tv[4]  = '{2'b00, 1, 1, 1, 1, 0, 0};
      tv[5]  = '{2'b01, 1, 1, 0, 0, 0, 0};
      tv[6]  = '{2'b11, 1, 1, 0, 0, 0, 0};
      tv[7]  = '{2'b10, 1, 1, 0, 0, 0, 0};
      tv[8]  = '{2'b11, 1, 1, 0, 0, 0, 0};
      tv[9]  = '{2'b01, 1, 1, 0, 0, 0, 0};
      tv[10] = '{2'b00, 1, 1, 0, 0, 0, 0};
      tv[11] = '{2'b10, 1, 1, 0, 0, 0, 0};
      tv[12] = '{2'b11, 1, 1, 0, 0, 0, 0};
      tv[13] = '{2'b01, 1, 1, 0, 0, 0, 0};
      tv[14] = '{2'b00, 1, 0, 1, 0, 0, 0};
      tv[15] = '{2'b10, 1, 0, 0, 0, 0, 0};
      tv[16] = '{2'b11, 1, 0, 0, 0, 0, 0};
      tv[17] = '{2'b01, 1, 0, 0, 0, 0, 0};
      tv[18] = '{2'b00, 1, WRAP ? MAXP : 0, 1, 0, 0, 0};
      tv[19] = '{2'b01, 1, WRAP ? MAXP : 0, 0, 0, 0, 0};
      tv[20] = '{2'b11, 0, WRAP ? MAXP : 0, 0, 0, 0, 0};
      tv[21] = '{2'b10, 0, WRAP ? MAXP : 0, 0, 0, 0, 0};
      tv[22] = '{2'b00, 0, WRAP ? 0 : 1, 1, 1, 0, 0};
      tv[23] = '{2'b01, 0, WRAP ? 0 : 1, 1, 1, 0, 0};
      tv[24] = '{2'b11, 0, WRAP ? 0 : 1, 1, 1, 0, 0};
      tv[25] = '{2'b10, 0, WRAP ? 0 : 1, 1, 1, 0, 0};
      tv[26] = '{2'b00, 0, WRAP ? 1 : 2, 1, 1, 0, 1};
      tv[27] = '{2'b00, 1, WRAP ? 1 : 2, 0, 0, 0, 1};
      tv[28] = '{2'b11, 1, WRAP ? 1 : 2, 0, 0, 1, 1};

      reset = 1'b1; clr = 1'b0; ab = 2'b00; ready = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      chk("reset_pos", pos, 0);
      chk("reset_valid", valid, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int t = 0; t < 10; t++) next_tick();
      chk("idle_pos", pos, 0);
      chk("idle_valid", valid, 0);
      chk("idle_err", err, 0);

      for (int i = 0; i < 29; i++) begin
         ab    = tv[i].ab;
         ready = tv[i].ready;
         next_tick();
         chk($sformatf("t%0d_pos", i), pos, tv[i].pos);
         chk($sformatf("t%0d_valid", i), valid, tv[i].valid);
         if (tv[i].valid) chk($sformatf("t%0d_dir", i), dir, tv[i].dir);
         chk($sformatf("t%0d_err", i), err, tv[i].err);
         chk($sformatf("t%0d_drop", i), drop, tv[i].drop);
      end

      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_err", err, 0);
      chk("clr_pos", pos, 0);
      chk("clr_drop", drop, 0);
      chk("clr_valid", valid, 0);
      ab = 2'b01;
      next_tick();
      chk("prime_pos", pos, 0);
      chk("prime_valid", valid, 0);
      for (int k = 2; k < 6; k++) begin
         ab = seq[k % 4];
         next_tick();
      end
      chk("post_clr_pos", pos, 1);
      chk("post_clr_valid", valid, 1);
      chk("post_clr_dir", dir, 1);

      ready = 1'b0;
      ab = 2'b11;
      next_tick();
      ab = 2'b10;
      next_tick();
      chk("middet_valid", valid, 1);
      chk("middet_pos", pos, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_pos", pos, 0);
      chk("rst_valid", valid, 0);
      chk("rst_dir", dir, 0);
      chk("rst_err", err, 0);
      chk("rst_drop", drop, 0);
      reset = 1'b0; ab = 2'b00; ready = 1'b1;
      for (int k = 1; k <= 5 * D; k++) begin
         @(negedge clk);
         if (k == D)     ab = 2'b01;
         if (k == 2 * D) ab = 2'b11;
         if (k == 3 * D) ab = 2'b10;
         if (k == 4 * D) ab = 2'b00;
         if (k == 5 * D - 1) chk("rst_tick_early_valid", valid, 0);
         if (k == 5 * D) begin
            chk("rst_tick_valid", valid, 1);
            chk("rst_tick_pos", pos, 1);
         end
      end

      gi = 0;
      for (int t = 0; t < 4 * 22; t++) begin
         gi = (gi + 1) % 4;
         ab = seq[gi];
         next_tick();
      end
      chk("upper_bound_pos", pos, WRAP ? 2 : MAXP);

      for (int t = 0; t < 600; t++) begin
         r = $urandom_range(0, 99);
         if (t >= 300 && r < 2) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
         end
         r = $urandom_range(0, 99);
         if (r < 5) gi = (gi + 2) % 4;
         else if (r < ((t < 300) ? 80 : 35)) gi = (gi + 1) % 4;
         else if (r < ((t < 300) ? 92 : 85)) gi = (gi + 3) % 4;
         ab    = seq[gi];
         ready = ($urandom_range(0, 2) != 0);
         next_tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish before %0t", $time);
      $fatal(1);
   end

endmodule
